// File: rtl/entropy_collector_if.sv
// Bundle of the health-test-side inputs and conditioner-side FIFO outputs of
// the entropy collector; the collector uses the slave view.
interface entropy_collector_if #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4
);
    logic                       adc_in;
    logic                       oht_valid;
    logic                       perm_fail;
    logic                       debug_mode;
    logic                       full;
    logic [WORD_W-1:0]          dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic [$clog2(DEPTH+1)-1:0] fill_level;
    logic                       err_sticky;
    logic [15:0]                vn_discard_cnt;

    modport master (
        output adc_in, oht_valid, perm_fail, debug_mode, dout_ready,
        input  full, dout, dout_valid, fill_level, err_sticky, vn_discard_cnt
    );

    modport slave (
        input  adc_in, oht_valid, perm_fail, debug_mode, dout_ready,
        output full, dout, dout_valid, fill_level, err_sticky, vn_discard_cnt
    );
endinterface

// File: rtl/entropy_collector.sv
// Gated von Neumann debiaser (bypassable), MSB-first word packer and small
// word FIFO whose full flag back-pressures the upstream health test.
module entropy_collector #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    entropy_collector_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [BC_W-1:0]  LAST_BIT_C = BC_W'(WORD_W - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              pair_phase_q, pair_phase_d;
    logic              pair_bit_q, pair_bit_d;
    logic              err_sticky_q, err_sticky_d;
    logic [15:0]       discard_q, discard_d;

    logic              full;
    logic              dout_valid;
    logic              accept;
    logic              emit;
    logic              emit_bit;
    logic              push;
    logic              pop;

    assign full       = (count_q == DEPTH_C);
    assign dout_valid = (count_q != '0);

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        word_d       = word_q;
        bit_cnt_d    = bit_cnt_q;
        pair_phase_d = pair_phase_q;
        pair_bit_d   = pair_bit_q;
        err_sticky_d = err_sticky_q;
        discard_d    = discard_q;
        emit         = 1'b0;
        emit_bit     = 1'b0;
        push         = 1'b0;

        accept = bus.oht_valid && !bus.perm_fail && !err_sticky_q && !full;
        // A perm_fail cycle never pops: the flush below takes precedence.
        pop    = dout_valid && bus.dout_ready && !bus.perm_fail;

        if (accept) begin
            if (bus.debug_mode) begin
                emit         = 1'b1;
                emit_bit     = bus.adc_in;
                pair_phase_d = 1'b0;
            end else if (!pair_phase_q) begin
                pair_bit_d   = bus.adc_in;
                pair_phase_d = 1'b1;
            end else begin
                pair_phase_d = 1'b0;
                if (pair_bit_q != bus.adc_in) begin
                    emit     = 1'b1;
                    emit_bit = pair_bit_q;
                end else begin
                    discard_d = sat_inc16(discard_q);
                end
            end
        end

        if (emit) begin
            word_d = {word_q[WORD_W-2:0], emit_bit};
            if (bit_cnt_q == LAST_BIT_C) begin
                push      = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = word_d;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (bus.perm_fail) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            bit_cnt_d    = '0;
            word_d       = '0;
            pair_phase_d = 1'b0;
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            pair_phase_q <= 1'b0;
            pair_bit_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            discard_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            pair_phase_q <= pair_phase_d;
            pair_bit_q   <= pair_bit_d;
            err_sticky_q <= err_sticky_d;
            discard_q    <= discard_d;
        end
    end

    assign bus.full           = full;
    assign bus.dout           = mem_q[rd_ptr_q];
    assign bus.dout_valid     = dout_valid;
    assign bus.fill_level     = count_q;
    assign bus.err_sticky     = err_sticky_q;
    assign bus.vn_discard_cnt = discard_q;
endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector: bypass/VN packing, back-pressure,
// simultaneous push/pop, perm_fail flush and oht_valid gating.
module tb_entropy_collector;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [63:0] aaaa;
    logic [63:0] pat;
    logic [63:0] p1;
    logic [63:0] p2;
    logic [63:0] p3;

    entropy_collector_if #(.WORD_W(64), .DEPTH(4)) bus ();

    entropy_collector #(.WORD_W(64), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.adc_in = b;
        tick();
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 64; i++) send_bit(w[63-i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", bus.fill_level); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_sticky); end
        total++; if (bus.vn_discard_cnt !== 16'd0) begin bad++; $display("FAIL reset_vncnt got=%0d exp=0", bus.vn_discard_cnt); end
        total++; if (bus.dout !== 64'd0) begin bad++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        bus.debug_mode = 1'b1;
        bus.oht_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 63; i++) send_bit((i % 2) == 0);
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL bypass_early_valid got=%b exp=0", bus.dout_valid); end
        send_bit(1'b0);
        total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b exp=1", bus.dout_valid); end
        total++; if (bus.dout !== aaaa) begin bad++; $display("FAIL bypass_word got=%h exp=%h", bus.dout, aaaa); end
        total++; if (bus.fill_level !== 3'd1) begin bad++; $display("FAIL bypass_fill got=%0d exp=1", bus.fill_level); end
        bus.oht_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL bypass_pop_fill got=%0d exp=0", bus.fill_level); end
    endtask

    task automatic test_vn();
        bus.debug_mode = 1'b0;
        bus.oht_valid  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_bit(1'b1); send_bit(1'b0);
            send_bit(1'b0); send_bit(1'b1);
        end
        total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL vn_valid got=%b exp=1", bus.dout_valid); end
        total++; if (bus.dout !== aaaa) begin bad++; $display("FAIL vn_word got=%h exp=%h", bus.dout, aaaa); end
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0); send_bit(1'b0);
            send_bit(1'b1); send_bit(1'b1);
        end
        total++; if (bus.vn_discard_cnt !== 16'd8) begin bad++; $display("FAIL vn_discards got=%0d exp=8", bus.vn_discard_cnt); end
        total++; if (bus.fill_level !== 3'd1) begin bad++; $display("FAIL vn_no_emit_fill got=%0d exp=1", bus.fill_level); end
        bus.oht_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.debug_mode = 1'b1;
        bus.oht_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 256; i++) send_bit((i % 2) == 0);
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL bp_full got=%b exp=1", bus.full); end
        total++; if (bus.fill_level !== 3'd4) begin bad++; $display("FAIL bp_fill got=%0d exp=4", bus.fill_level); end
        for (int i = 0; i < 20; i++) send_bit((i % 3) == 0);
        total++; if (bus.fill_level !== 3'd4) begin bad++; $display("FAIL bp_hold_fill got=%0d exp=4", bus.fill_level); end
        total++; if (bus.dout !== aaaa) begin bad++; $display("FAIL bp_hold_word got=%h exp=%h", bus.dout, aaaa); end
        bus.adc_in     = 1'b0;
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL bp_release_full got=%b exp=0", bus.full); end
        total++; if (bus.fill_level !== 3'd3) begin bad++; $display("FAIL bp_release_fill got=%0d exp=3", bus.fill_level); end
        send_word(pat);
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL bp_resume_full got=%b exp=1", bus.full); end
        bus.oht_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.dout !== ((k < 3) ? aaaa : pat)) begin
                bad++; $display("FAIL bp_drain%0d got=%h exp=%h", k, bus.dout, (k < 3) ? aaaa : pat);
            end
            bus.dout_ready = 1'b1;
            tick();
            bus.dout_ready = 1'b0;
        end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL bp_drained_valid got=%b exp=0", bus.dout_valid); end
    endtask

    task automatic test_push_pop();
        bus.debug_mode = 1'b1;
        bus.oht_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        send_word(p1);
        send_word(p2);
        total++; if (bus.fill_level !== 3'd2) begin bad++; $display("FAIL pp_pre_fill got=%0d exp=2", bus.fill_level); end
        total++; if (bus.dout !== p1) begin bad++; $display("FAIL pp_head got=%h exp=%h", bus.dout, p1); end
        for (int i = 0; i < 63; i++) send_bit(p3[63-i]);
        bus.adc_in     = p3[0];
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        bus.oht_valid  = 1'b0;
        total++; if (bus.fill_level !== 3'd2) begin bad++; $display("FAIL pp_fill got=%0d exp=2", bus.fill_level); end
        total++; if (bus.dout !== p2) begin bad++; $display("FAIL pp_order1 got=%h exp=%h", bus.dout, p2); end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        total++; if (bus.dout !== p3) begin bad++; $display("FAIL pp_order2 got=%h exp=%h", bus.dout, p3); end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL pp_empty got=%0d exp=0", bus.fill_level); end
    endtask

    task automatic test_perm_fail();
        bus.debug_mode = 1'b1;
        bus.oht_valid  = 1'b1;
        bus.dout_ready = 1'b0;
        send_word(p1);
        send_word(p2);
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        bus.perm_fail = 1'b1;
        bus.dout_ready = 1'b1;
        tick();
        bus.perm_fail = 1'b0;
        bus.dout_ready = 1'b0;
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL pf_valid got=%b exp=0", bus.dout_valid); end
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL pf_fill got=%0d exp=0", bus.fill_level); end
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL pf_err got=%b exp=1", bus.err_sticky); end
        for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(0, 1)));
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL pf_blocked_fill got=%0d exp=0", bus.fill_level); end
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL pf_err_held got=%b exp=1", bus.err_sticky); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL pf_rst_err got=%b exp=0", bus.err_sticky); end
        send_word(pat);
        total++; if (bus.dout !== pat) begin bad++; $display("FAIL pf_restart_word got=%h exp=%h", bus.dout, pat); end
        total++; if (bus.fill_level !== 3'd1) begin bad++; $display("FAIL pf_restart_fill got=%0d exp=1", bus.fill_level); end
        bus.oht_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_gating();
        bus.debug_mode = 1'b0;
        bus.oht_valid  = 1'b0;
        for (int i = 0; i < 500; i++) send_bit(1'($urandom_range(0, 1)));
        total++; if (bus.fill_level !== 3'd0) begin bad++; $display("FAIL gate_fill got=%0d exp=0", bus.fill_level); end
        total++; if (bus.vn_discard_cnt !== 16'd0) begin bad++; $display("FAIL gate_vncnt got=%0d exp=0", bus.vn_discard_cnt); end
        bus.debug_mode = 1'b1;
        bus.oht_valid  = 1'b1;
        send_word(p1);
        bus.oht_valid = 1'b0;
        total++; if (bus.dout !== p1) begin bad++; $display("FAIL gate_first_word got=%h exp=%h", bus.dout, p1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        aaaa  = 64'hAAAA_AAAA_AAAA_AAAA;
        pat   = 64'h0123_4567_89AB_CDEF;
        p1    = 64'hDEAD_BEEF_0000_0001;
        p2    = 64'h8000_0000_1234_5678;
        p3    = 64'hC0FF_EE00_F00D_0003;
        rst            = 1'b1;
        bus.adc_in     = 1'b0;
        bus.oht_valid  = 1'b0;
        bus.perm_fail  = 1'b0;
        bus.debug_mode = 1'b0;
        bus.dout_ready = 1'b0;

        test_reset();
        test_bypass();
        test_vn();
        test_backpressure();
        test_push_pop();
        test_perm_fail();
        test_gating();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/entropy_collector.md
# entropy_collector

Downstream consumer of the online health test stage. Accepts raw entropy-source bits while the health test reports the source healthy. Removes bias with a von Neumann extractor, which can be bypassed in debug mode. Packs the surviving bits into words, buffers them in a small FIFO for the conditioner, and drives the `full` back-pressure that freezes the health test's sampling.

## Interface
Parameters:
- WORD_W, 64, output word width in bits; must be ≥ 2.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- adc_in  in  1  raw entropy bit, the same bit sampled by the health test this cycle.
- oht_valid  in  1  health test has passed its first calibration window.
- perm_fail  in  1  permanent failure from the health test.
- debug_mode  in  1  1 = bypass the von Neumann extractor.
- full  out  1  back-pressure to the health test; 1 = do not sample.
- dout  out  WORD_W  FIFO head word.
- dout_valid  out  1  `dout` holds a valid word.
- dout_ready  in  1  consumer accepts the word.
- fill_level  out  $clog2(DEPTH+1)  number of words in the FIFO.
- err_sticky  out  1  a perm_fail has been seen since reset.
- vn_discard_cnt  out  16  count of discarded von Neumann pairs; saturates at 16'hFFFF.

## Operation
- Accept condition: `accept = oht_valid && !perm_fail && !err_sticky && !full`. No state changes when `accept = 0`, except pops and the perm_fail handling below.
- Von Neumann mode (`debug_mode = 0`):
  - `pair_phase` toggles on each accept. Phase 0 stores the bit in `pair_bit`.
  - On phase 1, with stored bit a and current bit b:
    - a != b → emit a (pair 10 emits 1, pair 01 emits 0).
    - a == b → emit nothing; `vn_discard_cnt` += 1, saturating.
- Bypass mode (`debug_mode = 1`): every accepted bit is emitted. `pair_phase` is forced to 0.
- A change of `debug_mode` takes effect on the next accept and drops any half-pair.
- Packer:
  - Each emitted bit updates `word <= {word[WORD_W-2:0], bit}`, so the first bit lands in the MSB, and `bit_cnt` += 1.
  - On the WORD_W-th bit, the completed word is written to the FIFO at that same edge and `bit_cnt` returns to 0.
- FIFO:
  - Write pointer and read pointer are each $clog2(DEPTH) bits wide and wrap naturally.
  - A count register is $clog2(DEPTH+1) bits wide.
  - `fill_level = count`; `dout_valid = (count != 0)`; `dout = mem[rd_ptr]`.
  - Pop occurs on `dout_valid && dout_ready`.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - `full = (count == DEPTH)`, combinational from registers.
  - No push can occur when full, because no accept occurs when full.
- perm_fail:
  - In any cycle with `perm_fail = 1`: flush the FIFO (pointers and count to 0), clear `bit_cnt`, `word` and `pair_phase`, and set `err_sticky`.
  - A pop in that same cycle is ignored.
  - `err_sticky` stays set until rst, and blocks all accepts. The consumer sees `dout_valid = 0`.
- A partial word or half-pair is held indefinitely while `accept = 0`.

## Timing
- Reset values: `full` = 0, `dout_valid` = 0, `fill_level` = 0, `err_sticky` = 0, `vn_discard_cnt` = 0, `dout` = 0 (memory cleared).
- Latency: a word's final bit accepted at edge k gives `dout_valid = 1` and the word on `dout` in the cycle after edge k.
- Back-pressure: a push that makes count = DEPTH at edge k gives `full = 1` after edge k. The health test's `adc_in` in that cycle is not consumed.
- A pop at edge k while full gives `full = 0` after edge k. The accept resumes in that cycle.
- `err_sticky` rises the cycle after the first edge at which `perm_fail = 1` is sampled.
- `dout_valid` falls that same cycle.
- rst asserted mid-word or mid-pair: all state is cleared at the next edge and partial data is discarded.
- Throughput:
  - Bypass mode: 1 bit per cycle.
  - Von Neumann mode: at most 1 bit per 2 cycles.

## Test plan
- Bypass: `debug_mode = 1`, `oht_valid = 1`, 64 bits 1,0,1,0,… → `dout = 64'hAAAA_AAAA_AAAA_AAAA`. `dout_valid` rises the cycle after the 64th accept; `fill_level = 1`.
- Von Neumann: `debug_mode = 0`, 128 bits in pairs 10,01 repeated → one word `64'hAAAA_AAAA_AAAA_AAAA`. Then feed 8 pairs of 00/11 → no emission and `vn_discard_cnt = 8`.
- Back-pressure: `dout_ready = 0`, bypass, stream 256 bits → `full = 1` after the 4th word and `fill_level = 4`. Further `adc_in` toggling leaves FIFO contents unchanged. Pulse `dout_ready` for 1 cycle → `full` drops the next cycle and sampling resumes.
- Simultaneous push/pop: count = 2, final bit of a word in the same cycle as a pop → `fill_level` stays 2. Pop order is the oldest word first.
- perm_fail mid-word: 2 words buffered plus 30 bits packed, pulse `perm_fail` → `dout_valid = 0`, `fill_level = 0`, `err_sticky = 1`. 200 further bits are never emitted until rst, after which normal packing restarts at the MSB.
- Gating: `oht_valid = 0` for 500 cycles of random `adc_in` → `fill_level = 0` and `vn_discard_cnt = 0`. Assert `oht_valid`; the first accepted bit becomes the MSB of the first word.
